// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame field widths,
// checksum seed.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam logic [7:0]  CSUM_INIT = 8'h00;

  function automatic logic takes_bytes(input state_e s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// Running XOR of data bytes, used as the frame checksum when PROGRAM_LOADER_CHECKSUM_EN
// is defined.
module loader_xor_acc
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] d_i,
  output logic [BYTE_W-1:0] acc_o
);

  logic [BYTE_W-1:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i)
      acc_q <= CSUM_INIT;
    else if (en_i)
      acc_q <= acc_q ^ d_i;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that fills the 16-bit instruction memory and holds the CPU
// until the image is complete. Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
//   state     | meaning
//   S_IDLE    | after reset, waiting for start
//   S_LEN_HI  | expecting word-count high byte
//   S_LEN_LO  | expecting word-count low byte
//   S_DATA_HI | expecting instruction high byte
//   S_DATA_LO | expecting instruction low byte (write issued on accept)
//   S_CHECK   | expecting checksum byte
//   S_DONE    | image loaded, CPU released
//   S_ERROR   | load aborted, CPU held
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [15:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [LEN_W:0] CAPACITY = (LEN_W+1)'(1) << ADDR_W;

  state_e            state_q;
  logic [7:0]        len_hi_q, hi_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] wr_ptr_q, im_addr_q;
  logic [15:0]       im_wdata_q;
  logic              im_we_q, hold_q, done_q, error_q;

  logic              accept, start_take, csum_ok;
  logic [LEN_W-1:0]  len_d;

  assign byte_ready_o = takes_bytes(state_q);
  assign accept       = byte_valid_i && byte_ready_o;
  assign start_take   = start_i && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign len_d        = {len_hi_q, byte_in_i};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [BYTE_W-1:0] csum;

  loader_xor_acc u_xor_acc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (start_take),
    .en_i    (accept && (state_q inside {S_DATA_HI, S_DATA_LO})),
    .d_i     (byte_in_i),
    .acc_o   (csum)
  );

  assign csum_ok = (csum == byte_in_i);
`else
  localparam bit CSUM_EN = 1'b0;
  assign csum_ok = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      hi_q       <= '0;
      rem_q      <= '0;
      wr_ptr_q   <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      im_we_q    <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          // DONE entered from the last write raises done one cycle after that write
          if (state_q == S_DONE) begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end
          if (start_i) begin
            state_q   <= S_LEN_HI;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b1;
            wr_ptr_q  <= '0;
            im_addr_q <= '0;
          end
        end
        S_LEN_HI: if (accept) begin
          len_hi_q <= byte_in_i;
          state_q  <= S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          rem_q <= len_d;
          if ({1'b0, len_d} > CAPACITY) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
          end else if (len_d == '0) begin
            if (CSUM_EN) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end
          end else begin
            state_q <= S_DATA_HI;
          end
        end
        S_DATA_HI: if (accept) begin
          hi_q    <= byte_in_i;
          state_q <= S_DATA_LO;
        end
        S_DATA_LO: if (accept) begin
          im_we_q    <= 1'b1;
          im_wdata_q <= {hi_q, byte_in_i};
          im_addr_q  <= wr_ptr_q;
          wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
          rem_q      <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1))
            state_q <= CSUM_EN ? S_CHECK : S_DONE;
          else
            state_q <= S_DATA_HI;
        end
        S_CHECK: if (accept) begin
          if (csum_ok) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign im_we_o    = im_we_q;
  assign im_addr_o  = im_addr_q;
  assign im_wdata_o = im_wdata_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame table plus hand-written sequences,
// with a write scoreboard fed from the stimulus.
module tb_program_loader;

  localparam int ADDR_W = 8;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, im_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .byte_in_i    (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .im_we_o      (im_we),
    .im_addr_o    (im_addr),
    .im_wdata_o   (im_wdata),
    .cpu_hold_o   (cpu_hold),
    .done_o       (done),
    .error_o      (error)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [47:0] bytes;
    logic [3:0]  nbytes;
    logic        bad_csum;
    logic [8:0]  exp_writes;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  first_we_cyc = -1;
  int  last_we_cyc = -1;
  wr_t sbq[$];

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && im_we) begin
      wr_t e;
      wr_cnt++;
      if (first_we_cyc < 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0h data=%0h", im_addr, im_wdata);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.addr));
        check("wr_data", 32'(im_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout byte=%0h actual=ready_low required=accepted", b);
    end
  endtask

  task automatic push_wr(input int a, input logic [15:0] d);
    wr_t e;
    e.addr = 8'(a);
    e.data = d;
    sbq.push_back(e);
  endtask

  // Wait for done/error after the final byte; returns cycles until the level is seen.
  task automatic wait_end(output int k);
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (done || error) begin
        k = j;
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 0);
    check({tag, "_we"},    32'(im_we), 0);
    check({tag, "_addr"},  32'(im_addr), 0);
    check({tag, "_wdata"}, 32'(im_wdata), 0);
    check({tag, "_hold"},  32'(cpu_hold), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] fb[$];
    logic [7:0] x = 8'h00;
    int n_words, w0, k, exp_lat;
    for (int i = 0; i < int'(v.nbytes); i++) fb.push_back(v.bytes[47-8*i -: 8]);
    n_words = int'({fb[0], fb[1]});
    if (n_words <= 256)
      for (int i = 0; 3 + 2*i < int'(v.nbytes); i++) push_wr(i, {fb[2+2*i], fb[3+2*i]});
    for (int i = 2; i < int'(v.nbytes); i++) x ^= fb[i];
    if (CSUM_EN && n_words <= 256) fb.push_back(v.bad_csum ? ~x : x);
    w0 = wr_cnt;
    pulse_start();
    @(negedge clk);
    check($sformatf("v%0d_hold_at_start", idx), 32'(cpu_hold), 1);
    check($sformatf("v%0d_done_cleared", idx), 32'(done | error), 0);
    tick();
    foreach (fb[i]) send_byte(fb[i], 0);
    wait_end(k);
    exp_lat = (v.exp_err || n_words == 0 || CSUM_EN) ? 1 : 2;
    check($sformatf("v%0d_latency", idx), 32'(k), 32'(exp_lat));
    check($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
    check($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_err));
    check($sformatf("v%0d_hold", idx), 32'(cpu_hold), 32'(v.exp_err));
    check($sformatf("v%0d_ready", idx), 32'(byte_ready), 0);
    check($sformatf("v%0d_writes", idx), 32'(wr_cnt - w0), 32'(v.exp_writes));
    check($sformatf("v%0d_sb_empty", idx), 32'(sbq.size()), 0);
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    int k, w0;
    logic [7:0] x;

    vecs[0] = '{bytes: 48'h0002_4021_8105, nbytes: 6, bad_csum: 0, exp_writes: 2, exp_done: 1, exp_err: 0};
    vecs[1] = '{bytes: 48'h0000_0000_0000, nbytes: 2, bad_csum: 0, exp_writes: 0, exp_done: 1, exp_err: 0};
    vecs[2] = '{bytes: 48'h0101_0000_0000, nbytes: 2, bad_csum: 0, exp_writes: 0, exp_done: 0, exp_err: 1};
    vecs[3] = '{bytes: 48'h0001_1234_0000, nbytes: 4, bad_csum: 1, exp_writes: 1, exp_done: !CSUM_EN, exp_err: CSUM_EN};
    vecs[4] = '{bytes: 48'h0001_FFFF_0000, nbytes: 4, bad_csum: 0, exp_writes: 1, exp_done: 1, exp_err: 0};
    vecs[5] = '{bytes: 48'h0002_0000_ABCD, nbytes: 6, bad_csum: 0, exp_writes: 2, exp_done: 1, exp_err: 0};

    repeat (3) tick();
    @(negedge clk);
    check_reset_vals("reset");
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // 256-word image: back-to-back writes ending at the top address
    first_we_cyc = -1;
    w0 = wr_cnt;
    x = 8'h00;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) push_wr(i, {8'(i), ~8'(i)});
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0);
      send_byte(~8'(i), 0);
      x ^= 8'(i) ^ ~8'(i);
    end
    if (CSUM_EN) send_byte(x, 0);
    wait_end(k);
    check("full_done", 32'(done), 1);
    check("full_error", 32'(error), 0);
    check("full_writes", 32'(wr_cnt - w0), 256);
    check("full_spacing", 32'(last_we_cyc - first_we_cyc), 510);
    check("full_last_addr", 32'(im_addr), 32'hFF);
    check("full_sb_empty", 32'(sbq.size()), 0);
    tick();

    // Mid-load start ignored, reset mid-load with irregular valid
    pulse_start();
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h03, $urandom_range(0, 2));
    push_wr(0, 16'hA1B2);
    send_byte(8'hA1, $urandom_range(0, 2));
    pulse_start();
    send_byte(8'hB2, $urandom_range(0, 2));
    send_byte(8'hC3, $urandom_range(0, 2));
    @(negedge clk);
    check("mid_hold", 32'(cpu_hold), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    check("mid_sb_empty", 32'(sbq.size()), 0);
    tick();

    run_vec(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
